vga_sync_gen: RTL and testbench

VGA 640x480@60 timing generator, directly downstream of the 50→25 MHz divider. Runs on clk_50 and consumes the divider's clk_25 output as a data signal: each clk_25 rising edge becomes a one-cycle pixel tick. Keeps horizontal and vertical counters and produces registered hsync, vsync, video_on, pixel coordinates and frame/pixel strobes for the pixel-colour stage.

---
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator running on clk_50.
// The divider's clk_25 output is treated as data: each rising edge becomes a
// one-cycle pixel tick that advances the horizontal/vertical counters.
// All outputs are registered and derived from the next counter values, so they
// change on the same clk_50 edge as the counters.
// H_TOTAL and V_TOTAL must both be <= 1024 to fit the 10-bit counters.
module vga_sync_gen #(
    parameter int unsigned H_VIS       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VIS       = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SYNC_ACTIVE = 0
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       clk_25,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_valid,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

    logic       clk_25_q;
    logic       tick;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       pix_valid_q, pix_valid_d;
    logic       frame_start_q, frame_start_d;

    // Rising-edge detect on clk_25 and next-state of the h/v counters
    always_comb begin
        tick = clk_25 & ~clk_25_q;
        h_d  = h_q;
        v_d  = v_q;
        if (tick) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Output decode from the next counter values so outputs align with counters
    always_comb begin
        hsync_d       = ((h_d >= HS_START) && (h_d <= HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = ((v_d >= VS_START) && (v_d <= VS_END)) ? SYNC_ON : ~SYNC_ON;
        video_on_d    = (h_d < H_VIS_L) && (v_d < V_VIS_L);
        pix_valid_d   = tick;
        frame_start_d = tick && (h_d == '0) && (v_d == '0);
    end

    // State registers; reset parks the counters on the last position so the
    // first tick after release lands on (0,0)
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            clk_25_q      <= 1'b0;
            h_q           <= H_MAX;
            v_q           <= V_MAX;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            video_on_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            clk_25_q      <= clk_25;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen.
// u_big uses the 640x480 defaults for line-level behaviour; u_small uses a
// 16x8 raster with active-high sync so whole frames and vsync fit a short run.
module tb_vga_sync_gen;

    logic       clk_50 = 1'b0;
    logic       rst, clk_25;
    logic       hsync, vsync, video_on, pix_valid, frame_start;
    logic [9:0] pixel_x, pixel_y;

    logic       rst_s, clk_25_s;
    logic       hsync_s, vsync_s, video_on_s, pix_valid_s, frame_start_s;
    logic [9:0] pixel_x_s, pixel_y_s;

    int checks = 0;
    int errors = 0;

    always #10 clk_50 = ~clk_50;

    vga_sync_gen u_big (
        .clk_50(clk_50), .rst(rst), .clk_25(clk_25),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pix_valid(pix_valid), .frame_start(frame_start)
    );

    // H: 8 vis, fp 2, sync 3 (x 10..12), bp 3 -> 16; V: 4 vis, fp 1, sync 2 (y 5..6), bp 1 -> 8
    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(1)
    ) u_small (
        .clk_50(clk_50), .rst(rst_s), .clk_25(clk_25_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
        .pixel_x(pixel_x_s), .pixel_y(pixel_y_s),
        .pix_valid(pix_valid_s), .frame_start(frame_start_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive both clk_25 inputs, cross one rising edge, settle 2 ns past it
    task automatic step(input logic cb, input logic cs);
        clk_25   = cb;
        clk_25_s = cs;
        @(posedge clk_50);
        #2;
    endtask

    task automatic pix_b(input int n);
        repeat (n) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    endtask

    task automatic pix_s(input int n);
        repeat (n) begin step(1'b0, 1'b1); step(1'b0, 1'b0); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x_bad, von_fall, hs_first, hs_low, pv_bad, fs_bad, stuck_bad;
        int fs_cyc, vs_cnt, hs_cnt, von_cnt, vs_first;

        rst = 1'b1; rst_s = 1'b1; clk_25 = 1'b0; clk_25_s = 1'b0;
        repeat (3) @(posedge clk_50);
        #2;

        // Reset state
        chk("rst_x", pixel_x, 799);
        chk("rst_y", pixel_y, 524);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_s_x", pixel_x_s, 15);
        chk("rst_s_y", pixel_y_s, 7);
        chk("rst_s_hsync", hsync_s, 0);
        chk("rst_s_vsync", vsync_s, 0);

        rst = 1'b0; rst_s = 1'b0;
        step(1'b0, 1'b0);
        chk("idle_x", pixel_x, 799);
        chk("idle_pix_valid", pix_valid, 0);

        // First tick lands on (0,0)
        step(1'b1, 1'b0);
        chk("first_x", pixel_x, 0);
        chk("first_y", pixel_y, 0);
        chk("first_video_on", video_on, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_pix_valid", pix_valid, 1);
        chk("first_hsync", hsync, 1);
        chk("first_vsync", vsync, 1);
        step(1'b0, 1'b0);
        chk("first_pv_drop", pix_valid, 0);
        chk("first_fs_drop", frame_start, 0);
        chk("first_x_hold", pixel_x, 0);

        // One full line of the default raster
        x_bad = 0; von_fall = -1; hs_first = -1; hs_low = 0; pv_bad = 0; fs_bad = 0;
        for (int k = 1; k < 800; k++) begin
            step(1'b1, 1'b0);
            if (pixel_x !== 10'(k) || pixel_y !== 10'd0) x_bad++;
            if (video_on === 1'b0 && von_fall < 0) von_fall = k;
            if (video_on !== (k < 640)) x_bad++;
            if (hsync === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = k; end
            if (pix_valid !== 1'b1) pv_bad++;
            if (frame_start !== 1'b0) fs_bad++;
            step(1'b0, 1'b0);
            if (hsync === 1'b0) hs_low++;
            if (pix_valid !== 1'b0) pv_bad++;
            if (frame_start !== 1'b0) fs_bad++;
        end
        chk("line_position_errs", x_bad, 0);
        chk("line_video_on_fall_x", von_fall, 640);
        chk("line_hsync_first_x", hs_first, 656);
        chk("line_hsync_low_cycles", hs_low, 192);
        chk("line_pix_valid_errs", pv_bad, 0);
        chk("line_frame_start_errs", fs_bad, 0);

        step(1'b1, 1'b0);
        chk("wrap_x", pixel_x, 0);
        chk("wrap_y", pixel_y, 1);
        chk("wrap_pix_valid", pix_valid, 1);
        chk("wrap_frame_start", frame_start, 0);
        chk("wrap_hsync", hsync, 1);
        step(1'b0, 1'b0);

        // clk_25 stuck high at pixel_x = 300
        pix_b(299);
        step(1'b1, 1'b0);
        chk("stuck1_x", pixel_x, 300);
        chk("stuck1_pv_entry", pix_valid, 1);
        stuck_bad = 0;
        repeat (49) begin
            step(1'b1, 1'b0);
            if (pixel_x !== 10'd300 || pix_valid !== 1'b0 || frame_start !== 1'b0) stuck_bad++;
        end
        chk("stuck1_hold_errs", stuck_bad, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("stuck1_resume_x", pixel_x, 301);
        chk("stuck1_resume_pv", pix_valid, 1);

        // clk_25 stuck low
        stuck_bad = 0;
        repeat (30) begin
            step(1'b0, 1'b0);
            if (pixel_x !== 10'd301 || pix_valid !== 1'b0 || frame_start !== 1'b0) stuck_bad++;
        end
        chk("stuck0_hold_errs", stuck_bad, 0);

        // Async reset mid-line while hsync is asserted
        pix_b(399);
        chk("pre_rst_x", pixel_x, 700);
        chk("pre_rst_y", pixel_y, 1);
        chk("pre_rst_hsync", hsync, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_hsync", hsync, 1);
        chk("async_rst_x", pixel_x, 799);
        chk("async_rst_y", pixel_y, 524);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk("post_rst_x", pixel_x, 0);
        chk("post_rst_y", pixel_y, 0);
        chk("post_rst_frame_start", frame_start, 1);
        step(1'b0, 1'b0);

        // Whole frame on the small raster; ticks on even cycles
        fs_cyc = 0; vs_cnt = 0; hs_cnt = 0; von_cnt = 0; vs_first = -1;
        for (int c = 0; c < 400; c++) begin
            step(1'b0, (c % 2 == 0));
            if (c == 0) begin
                chk("s_first_x", pixel_x_s, 0);
                chk("s_first_y", pixel_y_s, 0);
                chk("s_first_frame_start", frame_start_s, 1);
                chk("s_first_pix_valid", pix_valid_s, 1);
                chk("s_first_hsync", hsync_s, 0);
            end else if (frame_start_s === 1'b1) begin
                fs_cyc = c;
                break;
            end
            if (vsync_s === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(pixel_y_s);
            end
            if (hsync_s === 1'b1) hs_cnt++;
            if (video_on_s === 1'b1) von_cnt++;
        end
        chk("s_frame_period_cycles", fs_cyc, 256);
        chk("s_vsync_cycles", vs_cnt, 64);
        chk("s_vsync_first_line", vs_first, 5);
        chk("s_hsync_cycles", hs_cnt, 48);
        chk("s_video_on_cycles", von_cnt, 64);
        chk("s_wrap_x", pixel_x_s, 0);
        chk("s_wrap_y", pixel_y_s, 0);

        // Async reset with both syncs asserted, at (11,6)
        step(1'b0, 1'b0);
        pix_s(107);
        chk("s_pre_rst_x", pixel_x_s, 11);
        chk("s_pre_rst_y", pixel_y_s, 6);
        chk("s_pre_rst_hsync", hsync_s, 1);
        chk("s_pre_rst_vsync", vsync_s, 1);
        #3 rst_s = 1'b1;
        #1;
        chk("s_async_rst_hsync", hsync_s, 0);
        chk("s_async_rst_vsync", vsync_s, 0);
        chk("s_async_rst_x", pixel_x_s, 15);
        chk("s_async_rst_y", pixel_y_s, 7);
        step(1'b0, 1'b0);
        rst_s = 1'b0;
        step(1'b0, 1'b1);
        chk("s_post_rst_x", pixel_x_s, 0);
        chk("s_post_rst_y", pixel_y_s, 0);
        chk("s_post_rst_frame_start", frame_start_s, 1);
        chk("big_unaffected_x", pixel_x, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
